// File: rtl/uart_cmd_seq.sv
// Command sequencer behind uart_rx: parses "*W<A><DDDD><CR>" / "*R<A><CR>" frames
// into register write/read strobes and answers each complete frame with 'K' or 'E'.
//
// state  | meaning
// IDLE   | waiting for '*', everything else dropped
// CMD    | expecting W/w or R/r
// ADDR   | expecting one hex address digit
// DATA   | shifting in four hex data digits (dig_cnt counts them)
// EOL    | expecting CR to commit the command
// RSP    | holding the response until rsp_rdy
module uart_cmd_seq #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_rdy,
    input  logic        frm_err,
    output logic        cmd_wr_en,
    output logic        cmd_rd_en,
    output logic [3:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic [7:0]  rsp_char,
    output logic        rsp_vld,
    input  logic        rsp_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_EOL,
        S_RSP
    } state_t;

    localparam int unsigned     TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_E    = 8'h45;

    state_t           state, state_nxt;
    logic             is_wr, is_wr_nxt;
    logic [3:0]       addr_sh, addr_sh_nxt;
    logic [15:0]      data_sh, data_sh_nxt;
    logic [1:0]       dig_cnt, dig_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             wr_en_nxt, rd_en_nxt;
    logic [3:0]       cmd_addr_nxt;
    logic [15:0]      cmd_data_nxt;
    logic             rsp_vld_nxt;
    logic [7:0]       rsp_char_nxt;
    logic             err;
    logic             is_hex;
    logic [3:0]       hex_nib;

    always_comb begin
        is_hex  = 1'b1;
        hex_nib = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            hex_nib = rx_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            state     <= S_IDLE;
            is_wr     <= 1'b0;
            addr_sh   <= 4'h0;
            data_sh   <= 16'h0000;
            dig_cnt   <= 2'd0;
            tmo_cnt   <= '0;
            cmd_wr_en <= 1'b0;
            cmd_rd_en <= 1'b0;
            cmd_addr  <= 4'h0;
            cmd_data  <= 16'h0000;
            rsp_vld   <= 1'b0;
            rsp_char  <= 8'h00;
        end else begin
            state     <= state_nxt;
            is_wr     <= is_wr_nxt;
            addr_sh   <= addr_sh_nxt;
            data_sh   <= data_sh_nxt;
            dig_cnt   <= dig_cnt_nxt;
            tmo_cnt   <= tmo_nxt;
            cmd_wr_en <= wr_en_nxt;
            cmd_rd_en <= rd_en_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_data  <= cmd_data_nxt;
            rsp_vld   <= rsp_vld_nxt;
            rsp_char  <= rsp_char_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        is_wr_nxt    = is_wr;
        addr_sh_nxt  = addr_sh;
        data_sh_nxt  = data_sh;
        dig_cnt_nxt  = dig_cnt;
        tmo_nxt      = tmo_cnt;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        cmd_addr_nxt = cmd_addr;
        cmd_data_nxt = cmd_data;
        rsp_vld_nxt  = rsp_vld;
        rsp_char_nxt = rsp_char;
        err          = 1'b0;

        case (state)
            S_IDLE: begin
                tmo_nxt = '0;
                if (rx_data_rdy && !frm_err && rx_data == CH_STAR) begin
                    state_nxt = S_CMD;
                end
            end
            S_RSP: begin
                tmo_nxt = '0;
                if (rsp_rdy) begin
                    rsp_vld_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end
            S_CMD, S_ADDR, S_DATA, S_EOL: begin
                if (frm_err) begin
                    err = 1'b1;
                end else if (rx_data_rdy) begin
                    tmo_nxt = '0;
                    // '*' anywhere in a frame restarts it without complaint
                    if (rx_data == CH_STAR) begin
                        state_nxt = S_CMD;
                    end else begin
                        case (state)
                            S_CMD: begin
                                if (rx_data == 8'h57 || rx_data == 8'h77) begin
                                    is_wr_nxt = 1'b1;
                                    state_nxt = S_ADDR;
                                end else if (rx_data == 8'h52 || rx_data == 8'h72) begin
                                    is_wr_nxt = 1'b0;
                                    state_nxt = S_ADDR;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                            S_ADDR: begin
                                if (is_hex) begin
                                    addr_sh_nxt = hex_nib;
                                    dig_cnt_nxt = 2'd0;
                                    state_nxt   = is_wr ? S_DATA : S_EOL;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                            S_DATA: begin
                                if (is_hex) begin
                                    data_sh_nxt = {data_sh[11:0], hex_nib};
                                    dig_cnt_nxt = dig_cnt + 2'd1;
                                    if (dig_cnt == 2'd3) begin
                                        state_nxt = S_EOL;
                                    end
                                end else begin
                                    err = 1'b1;
                                end
                            end
                            S_EOL: begin
                                if (rx_data == CH_CR) begin
                                    cmd_addr_nxt = addr_sh;
                                    if (is_wr) begin
                                        cmd_data_nxt = data_sh;
                                        wr_en_nxt    = 1'b1;
                                    end else begin
                                        rd_en_nxt = 1'b1;
                                    end
                                    rsp_vld_nxt  = 1'b1;
                                    rsp_char_nxt = CH_K;
                                    state_nxt    = S_RSP;
                                end else begin
                                    err = 1'b1;
                                end
                            end
                            default: err = 1'b1;
                        endcase
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (err) begin
            tmo_nxt      = '0;
            rsp_vld_nxt  = 1'b1;
            rsp_char_nxt = CH_E;
            state_nxt    = S_RSP;
        end
    end

endmodule
